// File: rtl/clock_pkg.sv
// Shared constants and state encodings for the digital-clock counter chain.
package clock_pkg;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_e;

    function automatic logic [5:0] clamp6(input logic [5:0] value, input logic [5:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/mod_down_counter.sv
// Single 6-bit down-counting digit pair with clear, load and a wrap-to-MAX borrow.
module mod_down_counter #(
    parameter logic [5:0] MAX = 6'd59
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [5:0] value_i,
    input  logic       enable_i,
    output logic [5:0] count_o,
    output logic       borrow_o
);

    logic [5:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 6'd0;
        end else if (load_i) begin
            count_d = value_i;
        end else if (enable_i) begin
            // Compare before decrementing so the 6-bit value never underflows.
            count_d = (count_q == 6'd0) ? MAX : count_q - 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 6'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign borrow_o = enable_i && (count_q == 6'd0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: load/start/pause/clear control, 1 Hz decrement, done pulse and expired level.
module countdown_timer
    import clock_pkg::*;
#(
    parameter logic [5:0] MAX_MIN = clock_pkg::MIN_MAX,
    parameter logic [5:0] SEC_MAX = clock_pkg::SEC_MAX
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [5:0] load_min_i,
    input  logic [5:0] load_sec_i,
    input  logic       start_i,
    input  logic       pause_i,
    output logic [5:0] min_o,
    output logic [5:0] sec_o,
    output logic [1:0] state_o,
    output logic       running_o,
    output logic       done_o,
    output logic       expired_o
);

    timer_state_e state_q, state_d;
    logic         done_q, done_d;
    logic         cnt_clear, cnt_load, sec_en, min_en;
    logic         sec_borrow, min_borrow;
    logic [5:0]   min_cnt, sec_cnt;
    logic         is_zero, reach_zero;

    assign is_zero    = (min_cnt == 6'd0) && (sec_cnt == 6'd0);
    assign reach_zero = sec_en && (min_cnt == 6'd0) && (sec_cnt == 6'd1);
    // Minutes only borrow while non-zero, so the pair stops at 00:00 instead of wrapping.
    assign min_en     = sec_borrow && (min_cnt != 6'd0);

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        sec_en    = 1'b0;
        if (clear_i) begin
            cnt_clear = 1'b1;
            state_d   = ST_IDLE;
        end else if (load_i && state_q != ST_RUN) begin
            cnt_load = 1'b1;
            state_d  = ST_IDLE;
        end else if (pause_i && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
            state_d = ST_PAUSE;
        end else if (start_i && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
            if (!is_zero) begin
                state_d = ST_RUN;
            end
        end else if (tick_i && !load_i && state_q == ST_RUN) begin
            sec_en = 1'b1;
        end
        if (reach_zero || min_borrow) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    mod_down_counter #(.MAX(SEC_MAX)) u_sec (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cnt_clear),
        .load_i   (cnt_load),
        .value_i  (clamp6(load_sec_i, SEC_MAX)),
        .enable_i (sec_en),
        .count_o  (sec_cnt),
        .borrow_o (sec_borrow)
    );

    mod_down_counter #(.MAX(MAX_MIN)) u_min (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cnt_clear),
        .load_i   (cnt_load),
        .value_i  (clamp6(load_min_i, MAX_MIN)),
        .enable_i (min_en),
        .count_o  (min_cnt),
        .borrow_o (min_borrow)
    );

    assign min_o     = min_cnt;
    assign sec_o     = sec_cnt;
    assign state_o   = state_q;
    assign running_o = (state_q == ST_RUN);
    assign done_o    = done_q;
    assign expired_o = (state_q == ST_DONE);

endmodule
